// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler sharing one 7-bit serial transmitter
// between NREQ requesters. Captures the winner's data word, pulses tx_start
// for one cycle, holds tx_data for the frame, then waits an inter-frame gap.
//
// Ports:
//   clk         in   clock, rising edge
//   rstn        in   synchronous active-low reset
//   req         in   per-requester request level
//   req_data    in   flattened data, requester i owns [7*i+6:7*i]
//   gnt         out  one-hot one-cycle grant
//   tx_start    out  one-cycle start pulse to the transmitter
//   tx_data     out  data word to the transmitter
//   busy        out  high during LOAD, SEND, GAP
//   cur_id      out  index of the requester being served
//   frame_count out  16-bit frame counter (only with TX_ARBITER_FRAME_COUNT_EN)
//
// Optional feature macro: TX_ARBITER_FRAME_COUNT_EN
module tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned FRAME_CYCLES = 11,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req,
    input  logic [7*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           gnt,
    output logic                      tx_start,
    output logic [6:0]                tx_data,
    output logic                      busy,
`ifdef TX_ARBITER_FRAME_COUNT_EN
    output logic [15:0]               frame_count,
`endif
    output logic [$clog2(NREQ)-1:0]   cur_id
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam logic [7:0] FRAME_LOAD = 8'(FRAME_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             tx_start_q, tx_start_d;
    logic [6:0]       tx_data_q, tx_data_d;
    logic             busy_q, busy_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
`ifdef TX_ARBITER_FRAME_COUNT_EN
    logic [15:0]      frame_cnt_q, frame_cnt_d;
`endif

    logic             found;
    logic [IDW-1:0]   win_id;

    // Round-robin search: first set request at or above ptr, wrapping to 0.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req[(int'(ptr_q) + i) % int'(NREQ)]) begin
                found  = 1'b1;
                win_id = IDW'((int'(ptr_q) + i) % int'(NREQ));
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        cur_id_d   = cur_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
`ifdef TX_ARBITER_FRAME_COUNT_EN
        frame_cnt_d = frame_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (found) begin
                    // Grant outputs are registered here so they are visible during LOAD.
                    state_d    = S_LOAD;
                    gnt_d      = NREQ'(1) << win_id;
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    tx_data_d  = req_data[7*int'(win_id) +: 7];
                    cur_id_d   = win_id;
                    ptr_d      = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
                end
            end
            S_LOAD: begin
                state_d = S_SEND;
                cnt_d   = FRAME_LOAD;
`ifdef TX_ARBITER_FRAME_COUNT_EN
                frame_cnt_d = frame_cnt_q + 16'd1;
`endif
            end
            S_SEND: begin
                if (cnt_q == 8'd0) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            cur_id_q   <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
`ifdef TX_ARBITER_FRAME_COUNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            cur_id_q   <= cur_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
`ifdef TX_ARBITER_FRAME_COUNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign cur_id   = cur_id_q;
`ifdef TX_ARBITER_FRAME_COUNT_EN
    assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter: default instance plus a
// FRAME_CYCLES=3 / GAP_CYCLES=0 instance for back-to-back timing.
module tb_tx_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [3:0]  req, req2;
    logic [27:0] req_data, req_data2;
    logic [3:0]  gnt, gnt2;
    logic        tx_start, tx_start2;
    logic [6:0]  tx_data, tx_data2;
    logic        busy, busy2;
    logic [1:0]  cur_id, cur_id2;
`ifdef TX_ARBITER_FRAME_COUNT_EN
    logic [15:0] frame_count, frame_count2;
`endif

    tx_arbiter #(.NREQ(4), .FRAME_CYCLES(11), .GAP_CYCLES(1)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_data(req_data),
        .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
`ifdef TX_ARBITER_FRAME_COUNT_EN
        .frame_count(frame_count),
`endif
        .cur_id(cur_id)
    );

    tx_arbiter #(.NREQ(4), .FRAME_CYCLES(3), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .rstn(rstn), .req(req2), .req_data(req_data2),
        .gnt(gnt2), .tx_start(tx_start2), .tx_data(tx_data2), .busy(busy2),
`ifdef TX_ARBITER_FRAME_COUNT_EN
        .frame_count(frame_count2),
`endif
        .cur_id(cur_id2)
    );

    int checks = 0;
    int errors = 0;
    int n, low, cyc, expi;
    bit stb;
    logic [27:0] rd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next tx_start pulse of dut; report cycles taken and
    // whether tx_data stayed constant in between.
    task automatic wait_start(output int cycles, output bit stable);
        logic [6:0] d0;
        d0 = tx_data;
        cycles = 0;
        stable = 1'b1;
        do begin
            step();
            cycles++;
            if (!tx_start && tx_data !== d0) stable = 1'b0;
        end while (!tx_start && cycles < 60);
        chk("start_seen", 32'(tx_start), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 60) begin
            step();
            k++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; req = '0; req2 = '0; req_data = '0; req_data2 = '0;
        step(); step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cur_id", 32'(cur_id), 32'h0);
`ifdef TX_ARBITER_FRAME_COUNT_EN
        chk("rst_frame_count", 32'(frame_count), 32'h0);
`endif

        // Single request from requester 1.
        rstn = 1'b1; req = 4'b0010;
        req_data = {7'h33, 7'h22, 7'h5A, 7'h11};
        step();
        chk("t1_gnt", 32'(gnt), 32'h2);
        chk("t1_tx_start", 32'(tx_start), 32'h1);
        chk("t1_tx_data", 32'(tx_data), 32'h5A);
        chk("t1_cur_id", 32'(cur_id), 32'h1);
        req = '0;
        n = 0;
        while (busy && n < 60) begin
            n++;
            step();
        end
        chk("t1_busy_len", 32'(n), 32'd13);
        chk("t1_gnt_low", 32'(gnt), 32'h0);

        // Pointer is 2: search 2,3 empty, wrap to 0, then 1.
        req = 4'b0011;
        step();
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        chk("wrap_cur_id0", 32'(cur_id), 32'h0);
        chk("wrap_data0", 32'(tx_data), 32'h11);
        req = 4'b0010;
        wait_start(cyc, stb);
        chk("wrap_gnt1", 32'(gnt), 32'h2);
        chk("wrap_cur_id1", 32'(cur_id), 32'h1);
        chk("wrap_period", 32'(cyc), 32'd14);
        req = '0;
        wait_idle();
`ifdef TX_ARBITER_FRAME_COUNT_EN
        chk("fc_three", 32'(frame_count), 32'd3);
`endif

        // Rotation with all requests held.
        rstn = 1'b0; step(); rstn = 1'b1;
        req = 4'hF;
        req_data = {7'h44, 7'h33, 7'h22, 7'h11};
        rd = req_data;
        step();
        chk("rr_gnt0", 32'(gnt), 32'h1);
        chk("rr_data0", 32'(tx_data), 32'h11);
        for (int k = 1; k <= 4; k++) begin
            wait_start(cyc, stb);
            expi = k % 4;
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << expi));
            chk("rr_cur_id", 32'(cur_id), 32'(expi));
            chk("rr_data", 32'(tx_data), 32'(rd[7*expi +: 7]));
            chk("rr_period", 32'(cyc), 32'd14);
            chk("rr_data_stable", 32'(stb), 32'd1);
        end

        // Reset in the middle of SEND.
        req = '0;
        step(); step(); step();
        chk("mid_busy", 32'(busy), 32'h1);
        rstn = 1'b0;
        step();
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_tx_start", 32'(tx_start), 32'h0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'h0);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
`ifdef TX_ARBITER_FRAME_COUNT_EN
        chk("mid_rst_fc", 32'(frame_count), 32'h0);
`endif
        rstn = 1'b1; req = 4'b1000;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'h8);
        chk("post_rst_cur_id", 32'(cur_id), 32'h3);
        chk("post_rst_tx_start", 32'(tx_start), 32'h1);
        chk("post_rst_data", 32'(tx_data), 32'h44);
        req = '0;
        wait_idle();

`ifdef TX_ARBITER_FRAME_COUNT_EN
        // Frame counter wrap from 0xFFFF.
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        req = 4'b0001; step(); req = '0; wait_idle();
        req = 4'b0001; step(); req = '0; wait_idle();
        chk("fc_wrap", 32'(frame_count), 32'h1);
`endif

        // Zero-gap instance: 5-cycle period, busy low exactly one cycle.
        req2 = 4'b0001; req_data2 = {21'h0, 7'h2A};
        n = 0;
        while (!tx_start2 && n < 30) begin
            step();
            n++;
        end
        chk("g0_first_start", 32'(tx_start2), 32'd1);
        chk("g0_data", 32'(tx_data2), 32'h2A);
        for (int k = 0; k < 2; k++) begin
            n = 0; low = 0;
            do begin
                step();
                n++;
                if (!busy2) low++;
            end while (!tx_start2 && n < 30);
            chk("g0_period", 32'(n), 32'd5);
            chk("g0_busy_low", 32'(low), 32'd1);
        end
        req2 = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
